// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared definitions for the MDU issue controller.
//   - MD_* opcode constants carried on e_op/dp_op
//   - controller state encoding
//   - is_start()/is_div() opcode classifiers
package mdu_issue_ctrl_pkg;

   localparam int OP_W = 4;

   localparam logic [OP_W-1:0] MD_NONE  = 4'd0;
   localparam logic [OP_W-1:0] MD_MULT  = 4'd1;
   localparam logic [OP_W-1:0] MD_MULTU = 4'd2;
   localparam logic [OP_W-1:0] MD_DIV   = 4'd3;
   localparam logic [OP_W-1:0] MD_DIVU  = 4'd4;
   localparam logic [OP_W-1:0] MD_MFHI  = 4'd5;
   localparam logic [OP_W-1:0] MD_MFLO  = 4'd6;
   localparam logic [OP_W-1:0] MD_MTHI  = 4'd7;
   localparam logic [OP_W-1:0] MD_MTLO  = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_COMMIT = 2'd2
   } mdu_state_t;

   // Opcodes that occupy the datapath and end in a HI/LO commit.
   function automatic logic is_start(input logic [OP_W-1:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic is_div(input logic [OP_W-1:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/mdu_issue_ctrl_if.sv
// Bus between the E stage / MDU datapath and the issue controller.
//   E side   : req, e_valid, e_op, e_a, e_b  (driven by master)
//   DP side  : dp_op, dp_a, dp_b, hilo_we    (driven by slave)
//   HI/LO    : hi_we, lo_we, mt_data         (driven by slave)
//   Pipeline : busy, stall_e                 (driven by slave)
interface mdu_issue_ctrl_if;
   import mdu_issue_ctrl_pkg::*;

   logic            req;
   logic            e_valid;
   logic [OP_W-1:0] e_op;
   logic [31:0]     e_a;
   logic [31:0]     e_b;
   logic [OP_W-1:0] dp_op;
   logic [31:0]     dp_a;
   logic [31:0]     dp_b;
   logic            hilo_we;
   logic            hi_we;
   logic            lo_we;
   logic [31:0]     mt_data;
   logic            busy;
   logic            stall_e;

   modport master (
      output req, e_valid, e_op, e_a, e_b,
      input  dp_op, dp_a, dp_b, hilo_we, hi_we, lo_we, mt_data, busy, stall_e
   );

   modport slave (
      input  req, e_valid, e_op, e_a, e_b,
      output dp_op, dp_a, dp_b, hilo_we, hi_we, lo_we, mt_data, busy, stall_e
   );

endinterface

// File: rtl/mdu_lat_counter.sv
// Fixed-latency down counter: load a start value, decrement toward zero,
// flag zero. Holds at zero rather than wrapping.
//   clk, reset  : clock, synchronous active-high reset (count -> 0)
//   load_i      : load load_val_i (takes priority over dec_i)
//   load_val_i  : value to load
//   dec_i       : decrement when nonzero
//   cnt_o       : current count
//   zero_o      : count is zero
module mdu_lat_counter #(
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt_o  = cnt_q;
   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mdu_issue_ctrl.sv
// MDU issue/sequencing controller between E-stage decode and the
// multiply/divide datapath. Latches opcode and operands on issue, counts
// the fixed latency, pulses hilo_we for one cycle on completion, and
// stalls later MDU instructions in E while the unit is occupied.
//   clk, reset : clock, synchronous active-high reset
//   bus        : mdu_issue_ctrl_if.slave (E-side inputs, datapath/HI/LO
//                enables, busy and stall_e outputs)
module mdu_issue_ctrl
   import mdu_issue_ctrl_pkg::*;
#(
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10,
   parameter int CNT_W   = 5
) (
   input  logic             clk,
   input  logic             reset,
   mdu_issue_ctrl_if.slave  bus
);

   localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);

   mdu_state_t      state_q;
   logic            hilo_we_q;
   logic [OP_W-1:0] dp_op_q;
   logic [31:0]     dp_a_q;
   logic [31:0]     dp_b_q;

   logic             idle;
   logic             start;
   logic             mdu_use;
   logic [CNT_W-1:0] lat_ld;
   logic [CNT_W-1:0] cnt;
   logic             cnt_zero;

   assign idle    = (state_q == ST_IDLE);
   // A flushed E-stage instruction must never start the unit.
   assign start   = bus.e_valid && is_start(bus.e_op) && !bus.req;
   assign mdu_use = bus.e_valid && (bus.e_op != MD_NONE);
   assign lat_ld  = is_div(bus.e_op) ? DIV_LD : MUL_LD;

   mdu_lat_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk        (clk),
      .reset      (reset),
      .load_i     (idle && start),
      .load_val_i (lat_ld),
      .dec_i      (state_q == ST_RUN),
      .cnt_o      (cnt),
      .zero_o     (cnt_zero)
   );

   // req is deliberately not examined in RUN/COMMIT: the in-flight op
   // belongs to an instruction that has already left E.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         hilo_we_q <= 1'b0;
         dp_op_q   <= MD_NONE;
         dp_a_q    <= '0;
         dp_b_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               hilo_we_q <= 1'b0;
               if (start) begin
                  dp_op_q <= bus.e_op;
                  dp_a_q  <= bus.e_a;
                  dp_b_q  <= bus.e_b;
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (cnt_zero) begin
                  hilo_we_q <= 1'b1;
                  state_q   <= ST_COMMIT;
               end
            end
            ST_COMMIT: begin
               hilo_we_q <= 1'b0;
               state_q   <= ST_IDLE;
            end
            default: begin
               hilo_we_q <= 1'b0;
               state_q   <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.dp_op   = dp_op_q;
   assign bus.dp_a    = dp_a_q;
   assign bus.dp_b    = dp_b_q;
   assign bus.hilo_we = hilo_we_q;
   assign bus.busy    = !idle;
   // The issuing instruction sees IDLE, so it is never stalled; mfhi/mflo
   // are held through COMMIT so they observe the committed result.
   assign bus.stall_e = mdu_use && !idle;
   assign bus.hi_we   = idle && bus.e_valid && (bus.e_op == MD_MTHI) && !bus.req;
   assign bus.lo_we   = idle && bus.e_valid && (bus.e_op == MD_MTLO) && !bus.req;
   assign bus.mt_data = bus.e_a;

   // Count only ever sees values loaded from MUL_LD/DIV_LD, so unused here.
   logic unused_cnt;
   assign unused_cnt = ^cnt;

endmodule
